// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

    localparam int unsigned ByteWidth          = 8;
    // 50 MHz / 115200 baud, 8N1 = 4340 cycles, plus guard.
    localparam int unsigned DefaultFrameCycles = 4400;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStart,
        StWait
    } sched_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy; pointers carry an extra MSB so full and empty
// are distinguishable.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign level_o = level_q;

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between buffered key events and a valid/ready aux source, pacing one
// frame at a time with a bounded key burst before aux gets a turn.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned FRAME_CYCLES = DefaultFrameCycles,
    parameter int unsigned KEY_BURST    = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [ByteWidth-1:0]          key_event,
    input  logic                          on_event,
    input  logic [ByteWidth-1:0]          aux_data,
    input  logic                          aux_valid,
    output logic                          aux_ready,
    output logic [ByteWidth-1:0]          uart_din,
    output logic                          uart_en,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int unsigned FW = $clog2(FRAME_CYCLES);
    localparam int unsigned BW = $clog2(KEY_BURST + 1);
    // LOAD and START take two cycles of the frame; WAIT covers the rest.
    localparam logic [FW-1:0] WaitLast = FW'(FRAME_CYCLES - 3);
    localparam logic [BW-1:0] BurstMax = BW'(KEY_BURST);

    sched_state_e         state_q, state_d;
    logic [FW-1:0]        frame_cnt_q, frame_cnt_d;
    logic [BW-1:0]        burst_q, burst_d;
    logic [ByteWidth-1:0] din_q, din_d;
    logic                 overflow_q, overflow_d;

    logic                 key_pop;
    logic [ByteWidth-1:0] fifo_rdata;
    logic                 fifo_full, fifo_empty;

    sync_fifo #(
        .WIDTH (ByteWidth),
        .DEPTH (FIFO_DEPTH)
    ) u_key_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .push_i  (on_event),
        .wdata_i (key_event),
        .pop_i   (key_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        burst_d     = burst_q;
        din_d       = din_q;
        key_pop     = 1'b0;
        aux_ready   = 1'b0;
        unique case (state_q)
            // on_event is included so a key into an empty FIFO reaches LOAD one cycle later.
            StIdle: begin
                if (!fifo_empty || on_event || aux_valid) state_d = StLoad;
            end
            StLoad: begin
                if (!fifo_empty && !(aux_valid && burst_q == BurstMax)) begin
                    key_pop = 1'b1;
                    din_d   = fifo_rdata;
                    burst_d = aux_valid ? burst_q + 1'b1 : '0;
                    state_d = StStart;
                end else if (aux_valid) begin
                    aux_ready = 1'b1;
                    din_d     = aux_data;
                    burst_d   = '0;
                    state_d   = StStart;
                end else begin
                    // Aux request withdrawn before it could be granted.
                    state_d = StIdle;
                end
            end
            StStart: begin
                frame_cnt_d = '0;
                state_d     = StWait;
            end
            StWait: begin
                if (frame_cnt_q == WaitLast) state_d = StIdle;
                else                         frame_cnt_d = frame_cnt_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    assign overflow_d = overflow_q | (on_event & fifo_full & ~key_pop);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            frame_cnt_q <= '0;
            burst_q     <= '0;
            din_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            burst_q     <= burst_d;
            din_q       <= din_d;
            overflow_q  <= overflow_d;
        end
    end

    assign uart_din = din_q;
    assign uart_en  = (state_q == StStart);
    assign busy     = (state_q != StIdle);
    assign overflow = overflow_q;

endmodule
